// File: rtl/mul8_rr_sched.sv
// rtl/mul8_rr_sched.sv - round-robin scheduler sharing one registered 8x8 unsigned multiplier
module mul8_rr_sched #(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*8-1:0]       req_a,
    input  logic [NREQ*8-1:0]       req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [15:0]             rsp_data,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    input  logic                    rsp_ready,
    output logic                    busy,
    output logic [15:0]             op_count
);

    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ID_W-1:0]   ptr;
    logic [7:0]        a_r;
    logic [7:0]        b_r;
    logic [ID_W-1:0]   id_r;

    logic              any_valid;
    logic              upper_hit;
    logic [ID_W-1:0]   upper_id;
    logic [ID_W-1:0]   lower_id;
    logic [ID_W-1:0]   grant_id;
    logic [7:0]        grant_a;
    logic [7:0]        grant_b;
    logic [ID_W-1:0]   ptr_nxt;

    logic              accept;
    logic              rsp_fire;

    // Round-robin search split in two: the lowest requester at or above ptr
    // wins; if there is none, the search wraps to the lowest requester overall.
    always_comb begin
        any_valid = 1'b0;
        upper_hit = 1'b0;
        upper_id  = '0;
        lower_id  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_valid = 1'b1;
                lower_id  = ID_W'(i);
                if (i >= int'(ptr)) begin
                    upper_hit = 1'b1;
                    upper_id  = ID_W'(i);
                end
            end
        end
        grant_id = upper_hit ? upper_id : lower_id;
    end

    always_comb begin
        grant_a = '0;
        grant_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                grant_a = req_a[8*i +: 8];
                grant_b = req_b[8*i +: 8];
            end
        end
    end

    assign ptr_nxt = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req_ready is gated by rst_n so no strobe escapes while reset is held.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rsp_fire  = 1'b0;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (any_valid && rst_n) begin
                    accept    = 1'b1;
                    req_ready = NREQ'(1) << grant_id;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr  <= '0;
            a_r  <= '0;
            b_r  <= '0;
            id_r <= '0;
        end else if (accept) begin
            ptr  <= ptr_nxt;
            a_r  <= grant_a;
            b_r  <= grant_b;
            id_r <= grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            op_count  <= '0;
        end else begin
            if (state == CALC) begin
                rsp_valid <= 1'b1;
                rsp_data  <= 16'(a_r) * 16'(b_r);
                rsp_id    <= id_r;
            end else if (rsp_fire) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + 16'd1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
